// File: rtl/bibp_pkg.sv
// Shared definitions for the bibp_ardisil ALU slice: opcodes, FSM states, datapath modes.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bibp_pkg;

  // 4-bit opcodes
  localparam logic [3:0] TOPLA       = 4'b0000;
  localparam logic [3:0] CIKAR       = 4'b0001;
  localparam logic [3:0] B_AND       = 4'b0010;
  localparam logic [3:0] B_OR        = 4'b0011;
  localparam logic [3:0] AND_R       = 4'b0100;
  localparam logic [3:0] OR_R        = 4'b0101;
  localparam logic [3:0] CIFT_ESLIK  = 4'b0110;
  localparam logic [3:0] TEK_ESLIK   = 4'b0111;
  localparam logic [3:0] B_XOR       = 4'b1000;
  localparam logic [3:0] SOLA_KAYDIR = 4'b1001;
  localparam logic [3:0] SAGA_KAYDIR = 4'b1010;
  localparam logic [3:0] ARIT_SAGA   = 4'b1011;
  localparam logic [3:0] CARP        = 4'b1100;
  localparam logic [3:0] BOL         = 4'b1101;
  localparam logic [3:0] BIRIKTIR    = 4'b1110;
  localparam logic [3:0] ACC_SIFIRLA = 4'b1111;

  // Iterative datapath mode select
  localparam logic MOD_CARP = 1'b0;
  localparam logic MOD_BOL  = 1'b1;

  typedef enum logic [1:0] {
    BOS     = 2'd0,
    HESAPLA = 2'd1,
    SONUC   = 2'd2
  } durum_t;

  // True for the ops that run through the iterative multiply/divide datapath
  function automatic logic cok_dongulu(input logic [3:0] op);
    return (op == CARP) || (op == BOL);
  endfunction

endpackage

// File: rtl/bibp_ardisil_if.sv
// Command/result bundle for bibp_ardisil: command in with valid/ready, result out with valid/ready plus flags.
// Latency: n/a (wires only).
// Backpressure: buyruk_hazir and sonuc_hazir carry the ready side of each handshake.
// Ports: buyruk_gecerli/buyruk_hazir/buyruk = command channel {op, A, B};
//        sonuc_gecerli/sonuc_hazir/sonuc = result channel; sifir/elde/tasma/hata = result flags.
interface bibp_ardisil_if #(
  parameter int UZUNLUK = 8
);
  logic                   buyruk_gecerli;
  logic                   buyruk_hazir;
  logic [2*UZUNLUK+3:0]   buyruk;
  logic                   sonuc_gecerli;
  logic                   sonuc_hazir;
  logic [2*UZUNLUK-1:0]   sonuc;
  logic                   sifir;
  logic                   elde;
  logic                   tasma;
  logic                   hata;

  // Command source / result consumer side
  modport master (
    output buyruk_gecerli, buyruk, sonuc_hazir,
    input  buyruk_hazir, sonuc_gecerli, sonuc, sifir, elde, tasma, hata
  );

  // ALU side
  modport slave (
    input  buyruk_gecerli, buyruk, sonuc_hazir,
    output buyruk_hazir, sonuc_gecerli, sonuc, sifir, elde, tasma, hata
  );
endinterface

// File: rtl/seri_carp_bol.sv
// Iterative unsigned multiply (shift-add) / restoring divide, one step per clock.
// Latency: start latches operands; UZUNLUK steps follow, done is high during the last step.
// Backpressure: none; the caller starts it only when it can take the result.
// Ports: clk, rst_n; start/mode/a/b = launch; done = last step this cycle;
//        sonuc = result after the current step ({kalan, bolum} for divide); hata = divide by zero.
module seri_carp_bol
  import bibp_pkg::*;
#(
  parameter int UZUNLUK = 8,
  parameter int SAYAC_W = $clog2(UZUNLUK + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   mode,
  input  logic [UZUNLUK-1:0]     a,
  input  logic [UZUNLUK-1:0]     b,
  output logic                   done,
  output logic [2*UZUNLUK-1:0]   sonuc,
  output logic                   hata
);
  localparam int U = UZUNLUK;
  localparam int W = 2 * UZUNLUK;

  logic               calisiyor;
  logic [SAYAC_W-1:0] sayac;
  logic               mod_r;
  logic               sifira_bol_r;
  // multiply state
  logic [W-1:0]       carpan_r;   // multiplicand, shifted left each step
  logic [U-1:0]       carpici_r;  // multiplier, shifted right each step
  logic [W-1:0]       carpim_r;
  // divide state
  logic [U-1:0]       bolen_r;
  logic [U-1:0]       kalan_r;
  logic [U-1:0]       bolum_r;    // starts as the dividend, quotient bits shift in from the right

  logic [W-1:0]       carpim_n;
  logic [U:0]         kaydir;
  logic [U:0]         fark;
  logic [U-1:0]       kalan_n;
  logic [U-1:0]       bolum_n;

  always_comb begin
    carpim_n = carpim_r + (carpici_r[0] ? carpan_r : '0);
    kaydir   = {kalan_r, bolum_r[U-1]};
    fark     = kaydir - {1'b0, bolen_r};
    // Compare rather than test fark's sign: with a zero divisor kaydir can use all U+1 bits.
    // A zero divisor always "fits", which yields bolum = all ones and kalan = A.
    if (kaydir >= {1'b0, bolen_r}) begin
      kalan_n = fark[U-1:0];
      bolum_n = {bolum_r[U-2:0], 1'b1};
    end else begin
      kalan_n = kaydir[U-1:0];
      bolum_n = {bolum_r[U-2:0], 1'b0};
    end
  end

  assign done  = calisiyor && (sayac == SAYAC_W'(U - 1));
  assign sonuc = (mod_r == MOD_BOL) ? {kalan_n, bolum_n} : carpim_n;
  assign hata  = (mod_r == MOD_BOL) && sifira_bol_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calisiyor    <= 1'b0;
      sayac        <= '0;
      mod_r        <= MOD_CARP;
      sifira_bol_r <= 1'b0;
      carpan_r     <= '0;
      carpici_r    <= '0;
      carpim_r     <= '0;
      bolen_r      <= '0;
      kalan_r      <= '0;
      bolum_r      <= '0;
    end else if (start) begin
      calisiyor    <= 1'b1;
      sayac        <= '0;
      mod_r        <= mode;
      sifira_bol_r <= (b == '0);
      carpan_r     <= W'(a);
      carpici_r    <= b;
      carpim_r     <= '0;
      bolen_r      <= b;
      kalan_r      <= '0;
      bolum_r      <= a;
    end else if (calisiyor) begin
      carpan_r  <= carpan_r << 1;
      carpici_r <= carpici_r >> 1;
      carpim_r  <= carpim_n;
      kalan_r   <= kalan_n;
      bolum_r   <= bolum_n;
      if (done) begin
        calisiyor <= 1'b0;
        sayac     <= '0;
      end else begin
        sayac <= sayac + SAYAC_W'(1);
      end
    end
  end

endmodule

// File: rtl/bibp_ardisil.sv
// Registered ALU with accumulator and iterative multiply/divide behind valid/ready handshakes.
// Latency: 1 cycle for single-cycle ops, UZUNLUK+1 cycles for CARP/BOL; one command in flight.
// Backpressure: buyruk_hazir only in BOS; result and flags held while sonuc_hazir is low.
// Ports: clk, rst_n (async, active-low); bus = bibp_ardisil_if.slave (command/result channels + flags).
//        The interface instance must be built with the same UZUNLUK as this module.
module bibp_ardisil
  import bibp_pkg::*;
#(
  parameter int UZUNLUK = 8,
  parameter int SAYAC_W = $clog2(UZUNLUK + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  bibp_ardisil_if.slave  bus
);
  localparam int U = UZUNLUK;
  localparam int W = 2 * UZUNLUK;
  localparam logic [U:0] U_SINIR = (U + 1)'(U);

  durum_t       durum_r, durum_n;
  logic [3:0]   op;
  logic [U-1:0] a, b;
  logic         kabul;

  logic [W-1:0] sonuc_r;
  logic         sifir_r, elde_r, tasma_r, hata_r;
  logic [W-1:0] acc_r, acc_n;

  logic [W-1:0] tek_sonuc;
  logic         tek_elde, tek_tasma;
  logic [U:0]   toplam, fark;
  logic [U-1:0] kay;

  logic         cb_start, cb_mode, cb_done, cb_hata;
  logic [W-1:0] cb_sonuc;

  assign op    = bus.buyruk[2*U+3:2*U];
  assign a     = bus.buyruk[2*U-1:U];
  assign b     = bus.buyruk[U-1:0];
  assign kabul = bus.buyruk_gecerli && (durum_r == BOS);

  // Single-cycle ops and the accumulator's next value
  always_comb begin
    tek_sonuc = '0;
    tek_elde  = 1'b0;
    tek_tasma = 1'b0;
    acc_n     = acc_r;
    kay       = '0;
    toplam    = {1'b0, a} + {1'b0, b};
    fark      = {1'b0, a} - {1'b0, b};
    case (op)
      TOPLA: begin
        tek_sonuc = W'(toplam);
        tek_elde  = toplam[U];
        tek_tasma = (a[U-1] == b[U-1]) && (toplam[U-1] != a[U-1]);
      end
      CIKAR: begin
        tek_sonuc = W'(fark);
        tek_elde  = fark[U];  // borrow out of the U-bit subtract, i.e. A < B
        tek_tasma = (a[U-1] != b[U-1]) && (fark[U-1] != a[U-1]);
      end
      B_AND:      tek_sonuc = W'(a & b);
      B_OR:       tek_sonuc = W'(a | b);
      B_XOR:      tek_sonuc = W'(a ^ b);
      AND_R:      tek_sonuc = W'(&b);
      OR_R:       tek_sonuc = W'(|b);
      CIFT_ESLIK: tek_sonuc = W'(^b);
      TEK_ESLIK:  tek_sonuc = W'(~^b);
      SOLA_KAYDIR: begin
        kay       = ({1'b0, b} >= U_SINIR) ? '0 : (a << b);
        tek_sonuc = W'(kay);
      end
      SAGA_KAYDIR: begin
        kay       = ({1'b0, b} >= U_SINIR) ? '0 : (a >> b);
        tek_sonuc = W'(kay);
      end
      ARIT_SAGA: begin
        // Sign extends only within U bits; the upper half of sonuc stays zero.
        kay       = ({1'b0, b} >= U_SINIR) ? {U{a[U-1]}} : U'($signed(a) >>> b);
        tek_sonuc = W'(kay);
      end
      BIRIKTIR: begin
        acc_n     = acc_r + W'(a);
        tek_sonuc = acc_n;
      end
      ACC_SIFIRLA: begin
        acc_n     = '0;
        tek_sonuc = '0;
      end
      default: ;  // CARP/BOL come from the iterative datapath
    endcase
  end

  // Next-state logic
  always_comb begin
    durum_n  = durum_r;
    cb_start = 1'b0;
    cb_mode  = (op == BOL) ? MOD_BOL : MOD_CARP;
    case (durum_r)
      BOS: begin
        if (kabul) begin
          if (cok_dongulu(op)) begin
            cb_start = 1'b1;
            durum_n  = HESAPLA;
          end else begin
            durum_n  = SONUC;
          end
        end
      end
      HESAPLA: if (cb_done) durum_n = SONUC;
      SONUC:   if (bus.sonuc_hazir) durum_n = BOS;
      default: durum_n = BOS;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum_r <= BOS;
      sonuc_r <= '0;
      sifir_r <= 1'b0;
      elde_r  <= 1'b0;
      tasma_r <= 1'b0;
      hata_r  <= 1'b0;
      acc_r   <= '0;
    end else begin
      durum_r <= durum_n;
      // acc_n equals acc_r for every op except BIRIKTIR/ACC_SIFIRLA
      if (kabul) acc_r <= acc_n;
      if (kabul && !cok_dongulu(op)) begin
        sonuc_r <= tek_sonuc;
        sifir_r <= (tek_sonuc == '0);
        elde_r  <= tek_elde;
        tasma_r <= tek_tasma;
        hata_r  <= 1'b0;
      end else if ((durum_r == HESAPLA) && cb_done) begin
        sonuc_r <= cb_sonuc;
        sifir_r <= (cb_sonuc == '0);
        elde_r  <= 1'b0;
        tasma_r <= 1'b0;
        hata_r  <= cb_hata;
      end
    end
  end

  seri_carp_bol #(
    .UZUNLUK (UZUNLUK),
    .SAYAC_W (SAYAC_W)
  ) u_seri_carp_bol (
    .clk   (clk),
    .rst_n (rst_n),
    .start (cb_start),
    .mode  (cb_mode),
    .a     (a),
    .b     (b),
    .done  (cb_done),
    .sonuc (cb_sonuc),
    .hata  (cb_hata)
  );

  assign bus.buyruk_hazir  = (durum_r == BOS);
  assign bus.sonuc_gecerli = (durum_r == SONUC);
  assign bus.sonuc         = sonuc_r;
  assign bus.sifir         = sifir_r;
  assign bus.elde          = elde_r;
  assign bus.tasma         = tasma_r;
  assign bus.hata          = hata_r;

endmodule

// File: tb/tb_bibp_ardisil.sv
// Directed bench for bibp_ardisil (UZUNLUK=8) with an arithmetic reference model.
// Latency: checks 1-cycle and 9-cycle result latency from accept.
// Backpressure: holds sonuc_hazir low and drives stray commands while a result waits.
module tb_bibp_ardisil;
  localparam int U = 8;

  localparam int OP_TOPLA = 0,  OP_CIKAR = 1,  OP_AND = 2,  OP_OR = 3;
  localparam int OP_ANDR  = 4,  OP_ORR   = 5,  OP_CIFT = 6, OP_TEK = 7;
  localparam int OP_XOR   = 8,  OP_SOLA  = 9,  OP_SAGA = 10, OP_ARIT = 11;
  localparam int OP_CARP  = 12, OP_BOL   = 13, OP_BIR = 14, OP_ACC0 = 15;

  typedef struct {
    int sonuc;
    bit sifir;
    bit elde;
    bit tasma;
    bit hata;
    int lat;
  } bek_t;

  logic clk;
  logic rst_n;
  bibp_ardisil_if #(.UZUNLUK(U)) bus ();

  bibp_ardisil #(.UZUNLUK(U)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   model_acc;
  bek_t bek;
  bit   bekleyen;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string ad, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", ad, act, exp, $time);
    end
  endtask

  // Reference model: results from the arithmetic definition of each op
  function automatic bek_t model(input int op, input int a, input int b);
    bek_t r;
    int sa, sb, t;
    r.sonuc = 0; r.elde = 0; r.tasma = 0; r.hata = 0; r.lat = 1;
    sa = (a >= 128) ? a - 256 : a;
    sb = (b >= 128) ? b - 256 : b;
    case (op)
      OP_TOPLA: begin
        t = a + b; r.sonuc = t; r.elde = (t > 255);
        r.tasma = (sa + sb > 127) || (sa + sb < -128);
      end
      OP_CIKAR: begin
        r.sonuc = (a - b) & 'h1FF; r.elde = (a < b);
        r.tasma = (sa - sb > 127) || (sa - sb < -128);
      end
      OP_AND:  r.sonuc = a & b;
      OP_OR:   r.sonuc = a | b;
      OP_XOR:  r.sonuc = a ^ b;
      OP_ANDR: r.sonuc = (b == 255) ? 1 : 0;
      OP_ORR:  r.sonuc = (b != 0) ? 1 : 0;
      OP_CIFT: r.sonuc = ($countones(b) % 2 == 1) ? 1 : 0;
      OP_TEK:  r.sonuc = ($countones(b) % 2 == 0) ? 1 : 0;
      OP_SOLA: r.sonuc = (b >= U) ? 0 : ((a << b) & 255);
      OP_SAGA: r.sonuc = (b >= U) ? 0 : (a >> b);
      OP_ARIT: r.sonuc = (b >= U) ? ((a >= 128) ? 255 : 0) : ((sa >>> b) & 255);
      OP_CARP: begin r.sonuc = a * b; r.lat = U + 1; end
      OP_BOL: begin
        r.lat = U + 1;
        if (b == 0) begin r.sonuc = (a << 8) | 255; r.hata = 1; end
        else r.sonuc = ((a % b) << 8) | (a / b);
      end
      OP_BIR: begin model_acc = (model_acc + a) % 65536; r.sonuc = model_acc; end
      default: begin model_acc = 0; r.sonuc = 0; end
    endcase
    r.sifir = (r.sonuc == 0);
    return r;
  endfunction

  // Every cycle a result is presented, it must match the model and the block must not take commands
  always @(negedge clk) begin
    if (rst_n && bekleyen && bus.sonuc_gecerli) begin
      chk("sonuc", bus.sonuc, bek.sonuc);
      chk("sifir", bus.sifir, bek.sifir);
      chk("elde", bus.elde, bek.elde);
      chk("tasma", bus.tasma, bek.tasma);
      chk("hata", bus.hata, bek.hata);
      chk("hazir_while_valid", bus.buyruk_hazir, 0);
    end
  end

  // Issue one command, wait for its result, optionally hold backpressure, then consume.
  // lit_sonuc / lit_bayrak ({sifir,elde,tasma,hata}) are hand-computed values; -1 skips them.
  task automatic komut(input int op, input int a, input int b, input int hold,
                       input int lit_sonuc, input int lit_bayrak);
    int lat;
    @(negedge clk);
    chk("accept_ready", bus.buyruk_hazir, 1);
    bus.buyruk = {op[3:0], a[7:0], b[7:0]};
    bus.buyruk_gecerli = 1'b1;
    @(posedge clk); #1;
    bus.buyruk_gecerli = 1'b0;
    bek = model(op, a, b);
    bekleyen = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.sonuc_gecerli && lat < 40);
    chk("latency", lat, bek.lat);
    if (lit_sonuc >= 0) chk("lit_sonuc", bus.sonuc, lit_sonuc);
    if (lit_bayrak >= 0) chk("lit_flags", {bus.sifir, bus.elde, bus.tasma, bus.hata}, lit_bayrak);
    for (int i = 0; i < hold; i++) begin
      bus.buyruk = {4'(OP_TOPLA), 8'h11, 8'h22};
      bus.buyruk_gecerli = 1'b1;
      @(negedge clk);
    end
    bus.buyruk_gecerli = 1'b0;
    bus.sonuc_hazir = 1'b1;
    @(posedge clk); #1;
    bus.sonuc_hazir = 1'b0;
    bekleyen = 1'b0;
    @(negedge clk);
    chk("valid_drop", bus.sonuc_gecerli, 0);
    chk("ready_back", bus.buyruk_hazir, 1);
    chk("sonuc_held", bus.sonuc, bek.sonuc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  initial begin
    bit goruldu;
    rst_n = 1'b0;
    bus.buyruk_gecerli = 1'b0;
    bus.buyruk = '0;
    bus.sonuc_hazir = 1'b0;
    model_acc = 0;
    bekleyen = 1'b0;
    #12;
    chk("rst_valid", bus.sonuc_gecerli, 0);
    chk("rst_hazir", bus.buyruk_hazir, 1);
    chk("rst_sonuc", bus.sonuc, 0);
    chk("rst_flags", {bus.sifir, bus.elde, bus.tasma, bus.hata}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    komut(OP_TOPLA, 'hFF, 'h01, 0, 'h100, 'b0100);
    komut(OP_TOPLA, 'h7F, 'h01, 0, 'h080, 'b0010);
    komut(OP_CIKAR, 'h80, 'h01, 0, 'h07F, 'b0010);
    komut(OP_CIKAR, 'h03, 'h05, 0, 'h1FE, 'b0100);
    komut(OP_AND,   'hF0, 'h3C, 0, 'h030, -1);
    komut(OP_OR,    'hF0, 'h0C, 0, 'h0FC, -1);
    komut(OP_XOR,   'hAA, 'hAA, 0, 'h000, 'b1000);
    komut(OP_ANDR,  'h00, 'hFF, 0, 1, -1);
    komut(OP_ANDR,  'h00, 'hFE, 0, 0, -1);
    komut(OP_ORR,   'h55, 'h00, 0, 0, -1);
    komut(OP_CIFT,  'h00, 'h07, 0, 1, -1);
    komut(OP_TEK,   'h00, 'h07, 0, 0, -1);
    komut(OP_SOLA,  'h81, 1,    0, 'h02, -1);
    komut(OP_SOLA,  'h81, 8,    0, 0, -1);
    komut(OP_SAGA,  'h81, 7,    0, 1, -1);
    komut(OP_SAGA,  'h81, 200,  0, 0, -1);
    komut(OP_ARIT,  'h90, 9,    5, 'h00FF, 'b0000);
    komut(OP_ARIT,  'h90, 3,    0, 'h00F2, -1);
    komut(OP_ARIT,  'h70, 9,    0, 0, -1);
    komut(OP_CARP,  'hFF, 'hFF, 0, 'hFE01, 'b0000);
    komut(OP_CARP,  'h00, 'h37, 2, 0, 'b1000);
    komut(OP_BOL,   200,  7,    0, 'h041C, 'b0000);
    komut(OP_BOL,   'h2A, 0,    0, 'h2AFF, 'b0001);
    komut(OP_BOL,   5,    9,    0, 'h0500, -1);

    komut(OP_ACC0,  0, 0, 0, 0, 'b1000);
    for (int i = 0; i < 256; i++) komut(OP_BIR, 'hFF, 0, 0, -1, -1);
    komut(OP_BIR,   'hFF, 0, 0, 'hFFFF, 'b0000);
    komut(OP_BIR,   'h01, 0, 0, 0, 'b1000);       // wraps to zero
    komut(OP_BIR,   'h10, 0, 0, 'h10, -1);
    komut(OP_ACC0,  0, 0, 0, 0, 'b1000);
    komut(OP_BIR,   'h20, 0, 0, 'h20, -1);

    // Reset in the middle of a multiply
    @(negedge clk);
    bus.buyruk = {4'(OP_CARP), 8'h0F, 8'h0F};
    bus.buyruk_gecerli = 1'b1;
    @(posedge clk); #1;
    bus.buyruk_gecerli = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", bus.sonuc_gecerli, 0);
    chk("midrst_sonuc", bus.sonuc, 0);
    chk("midrst_hazir", bus.buyruk_hazir, 1);
    chk("midrst_flags", {bus.sifir, bus.elde, bus.tasma, bus.hata}, 0);
    model_acc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    goruldu = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.sonuc_gecerli) goruldu = 1'b1;
    end
    chk("no_result_after_reset", goruldu, 0);
    komut(OP_BIR,   'h01, 0, 0, 'h0001, -1);      // ACC was cleared by reset
    komut(OP_TOPLA, 2, 3, 0, 'h005, 'b0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
